// File: rtl/anita_trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : anita_trig_pkg
//  Description : Shared definitions for the ANITA L2 coincidence engine:
//                combination-rule encodings and the output FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package anita_trig_pkg;

    // Combination rule selected by mode_i
    localparam logic [1:0] MODE_ANY2   = 2'd0;  // any 2-of-3 (top-mid, top-bot, bot-mid)
    localparam logic [1:0] MODE_TOPREQ = 2'd1;  // top required: top-mid or top-bot
    localparam logic [1:0] MODE_ALL3   = 2'd2;  // top, mid and bot all coincident
    localparam logic [1:0] MODE_OFF    = 2'd3;  // L2 disabled

    // Per-sector output FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } l2_state_e;

endpackage
`default_nettype wire

// File: rtl/anita_win_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : anita_win_cnt
//  Description : Loadable, retriggerable coincidence-window down-counter.
//                A pulse loads win_i + SLOP (only when win_i is nonzero);
//                otherwise the count decays by one per clock to zero.
//                open_o is high while the count is nonzero.
//  Ports       : clk_i, rst_n_i  - clock, async active-low reset
//                pulse_i         - single-cycle load strobe
//                win_i           - window length in clocks (0 = never load)
//                open_o          - window currently open
//  Revision    : 1.0 - initial release
// ============================================================================
module anita_win_cnt #(
    parameter int WBITS = 3,
    parameter int SLOP  = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             pulse_i,
    input  logic [WBITS-1:0] win_i,
    output logic             open_o
);

    // One extra bit so that win_i + SLOP never wraps.
    localparam int CW = WBITS + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pulse_i && (win_i != '0)) begin
            cnt_d = {1'b0, win_i} + CW'(SLOP);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign open_o = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/anita_l2_coinc_nphi.sv
`default_nettype none
// ============================================================================
//  Module      : anita_l2_coinc_nphi
//  Description : L2 coincidence engine for NPHI phi sectors. Per sector, L1
//                ring pulses (top/mid/bot) are combined through programmable
//                coincidence windows under a selectable rule, and an accepted
//                coincidence produces a stretched L2 pulse, a one-cycle scaler
//                pulse and a saturating event count, followed by a holdoff.
//  Ports       : clk_i, rst_n_i       - clock, async active-low reset
//                l1_top/mid/bot_i     - per-sector single-cycle L1 pulses
//                mask_i               - per-sector L2 inhibit
//                mode_i               - combination rule (see anita_trig_pkg)
//                mt/bt/bm_win_i       - coincidence windows (0 = pairing off)
//                l2_width_i           - L2 high time (0 behaves as 1)
//                holdoff_i            - dead time after L2
//                cnt_clr_i            - synchronous clear of event counters
//                l2_o, l2_scaler_o    - stretched L2, accept strobe
//                l2_count_o           - packed per-sector counts
//  Revision    : 1.0 - initial release
// ============================================================================
module anita_l2_coinc_nphi
    import anita_trig_pkg::*;
#(
    parameter int NPHI  = 2,
    parameter int WBITS = 3,
    parameter int CBITS = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NPHI-1:0]         l1_top_i,
    input  logic [NPHI-1:0]         l1_mid_i,
    input  logic [NPHI-1:0]         l1_bot_i,
    input  logic [NPHI-1:0]         mask_i,
    input  logic [1:0]              mode_i,
    input  logic [WBITS-1:0]        mt_win_i,
    input  logic [WBITS-1:0]        bt_win_i,
    input  logic [WBITS-1:0]        bm_win_i,
    input  logic [WBITS-1:0]        l2_width_i,
    input  logic [WBITS-1:0]        holdoff_i,
    input  logic                    cnt_clr_i,
    output logic [NPHI-1:0]         l2_o,
    output logic [NPHI-1:0]         l2_scaler_o,
    output logic [NPHI*CBITS-1:0]   l2_count_o
);

    localparam logic [WBITS-1:0] W_ONE = WBITS'(1);

    // Zero width is stretched to a single cycle.
    logic [WBITS-1:0] width_eff;
    assign width_eff = (l2_width_i == '0) ? W_ONE : l2_width_i;

    for (genvar n = 0; n < NPHI; n++) begin : g_sector

        logic mt_open, bt_open, bm_m_open, bm_b_open;
        logic top_q, top_d, bm_q, bm_d;
        logic tm, tb, cond, accept;

        l2_state_e        state_q, state_d;
        logic [WBITS-1:0] tmr_q, tmr_d;
        logic [CBITS-1:0] cnt_q, cnt_d;
        logic             l2_q, l2_d, scl_q, scl_d;

        // mid->top and bot->top windows carry one clock of slop so that a
        // top sampled exactly win clocks after mid/bot still coincides.
        anita_win_cnt #(.WBITS(WBITS), .SLOP(1)) u_mt (
            .clk_i(clk_i), .rst_n_i(rst_n_i),
            .pulse_i(l1_mid_i[n]), .win_i(mt_win_i), .open_o(mt_open));

        anita_win_cnt #(.WBITS(WBITS), .SLOP(1)) u_bt (
            .clk_i(clk_i), .rst_n_i(rst_n_i),
            .pulse_i(l1_bot_i[n]), .win_i(bt_win_i), .open_o(bt_open));

        // bot<->mid is symmetric, so each side opens its own window and the
        // later pulse checks the other side's window.
        anita_win_cnt #(.WBITS(WBITS), .SLOP(0)) u_bm_m (
            .clk_i(clk_i), .rst_n_i(rst_n_i),
            .pulse_i(l1_mid_i[n]), .win_i(bm_win_i), .open_o(bm_m_open));

        anita_win_cnt #(.WBITS(WBITS), .SLOP(0)) u_bm_b (
            .clk_i(clk_i), .rst_n_i(rst_n_i),
            .pulse_i(l1_bot_i[n]), .win_i(bm_win_i), .open_o(bm_b_open));

        always_comb begin
            top_d = l1_top_i[n];
            // A zero bm window disables the pairing, same-cycle included.
            bm_d  = (bm_win_i != '0) &&
                    ((l1_mid_i[n] && (l1_bot_i[n] || bm_b_open)) ||
                     (l1_bot_i[n] && bm_m_open));
            tm    = top_q && mt_open;
            tb    = top_q && bt_open;
            case (mode_i)
                MODE_ANY2:   cond = tm || tb || bm_q;
                MODE_TOPREQ: cond = tm || tb;
                MODE_ALL3:   cond = top_q && mt_open && bt_open;
                MODE_OFF:    cond = 1'b0;
                default:     cond = 1'b0;
            endcase
        end

        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            accept  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cond && !mask_i[n]) begin
                        accept  = 1'b1;
                        state_d = ST_FIRE;
                        tmr_d   = width_eff;
                    end
                end
                ST_FIRE: begin
                    if (tmr_q <= W_ONE) begin
                        // The IDLE cycle that follows counts as one clock of
                        // dead time, so HOLD covers the remaining holdoff-1.
                        if (holdoff_i > W_ONE) begin
                            state_d = ST_HOLD;
                            tmr_d   = holdoff_i - W_ONE;
                        end else begin
                            state_d = ST_IDLE;
                            tmr_d   = '0;
                        end
                    end else begin
                        tmr_d = tmr_q - W_ONE;
                    end
                end
                ST_HOLD: begin
                    if (tmr_q <= W_ONE) begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q - W_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end
            endcase

            cnt_d = cnt_q;
            if (cnt_clr_i) begin
                cnt_d = '0;
            end else if (accept && (cnt_q != '1)) begin
                cnt_d = cnt_q + CBITS'(1);
            end

            // Outputs are registered off the state, so the first FIRE cycle
            // is the only one in which l2_q is still low.
            l2_d  = (state_q == ST_FIRE);
            scl_d = (state_q == ST_FIRE) && !l2_q;
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                top_q   <= 1'b0;
                bm_q    <= 1'b0;
                state_q <= ST_IDLE;
                tmr_q   <= '0;
                cnt_q   <= '0;
                l2_q    <= 1'b0;
                scl_q   <= 1'b0;
            end else begin
                top_q   <= top_d;
                bm_q    <= bm_d;
                state_q <= state_d;
                tmr_q   <= tmr_d;
                cnt_q   <= cnt_d;
                l2_q    <= l2_d;
                scl_q   <= scl_d;
            end
        end

        assign l2_o[n]                     = l2_q;
        assign l2_scaler_o[n]              = scl_q;
        assign l2_count_o[n*CBITS +: CBITS] = cnt_q;

    end : g_sector

endmodule
`default_nettype wire

// File: tb/tb_anita_l2_coinc_nphi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_anita_l2_coinc_nphi
//  Description : Self-checking bench for anita_l2_coinc_nphi. An event-level
//                reference model tracks the edge of the last window-opening
//                pulse per sector and the edge of the last accepted L2, and
//                predicts l2_o, l2_scaler_o and l2_count_o every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_anita_l2_coinc_nphi;

    localparam int NPHI = 2;
    localparam int WB   = 3;
    localparam int CB   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NPHI-1:0] top_r = '0, mid_r = '0, bot_r = '0, mask_r = '0;
    logic [1:0]      mode_r = 2'd0;
    logic [WB-1:0]   mt_r = '0, bt_r = '0, bm_r = '0, wid_r = '0, hold_r = '0;
    logic            clr_r = 1'b0;
    logic [NPHI-1:0]    l2_w, scl_w;
    logic [NPHI*CB-1:0] cnt_w;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    anita_l2_coinc_nphi #(.NPHI(NPHI), .WBITS(WB), .CBITS(CB)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .l1_top_i(top_r), .l1_mid_i(mid_r), .l1_bot_i(bot_r),
        .mask_i(mask_r), .mode_i(mode_r),
        .mt_win_i(mt_r), .bt_win_i(bt_r), .bm_win_i(bm_r),
        .l2_width_i(wid_r), .holdoff_i(hold_r), .cnt_clr_i(clr_r),
        .l2_o(l2_w), .l2_scaler_o(scl_w), .l2_count_o(cnt_w));

    // ---------------- reference model ----------------
    int e = 0;
    int mt_e[NPHI], mt_w[NPHI], bt_e[NPHI], bt_w[NPHI];
    int bmm_e[NPHI], bmm_w[NPHI], bmb_e[NPHI], bmb_w[NPHI];
    int acc_e[NPHI], acc_w[NPHI], next_ok[NPHI], cnt_m[NPHI];
    bit p_tm[NPHI], p_tb[NPHI], p_bm[NPHI];
    logic [NPHI-1:0]    exp_l2, exp_scl;
    logic [NPHI*CB-1:0] exp_cnt;

    task automatic model_reset();
        for (int n = 0; n < NPHI; n++) begin
            mt_e[n] = -1000; mt_w[n] = 0; bt_e[n] = -1000; bt_w[n] = 0;
            bmm_e[n] = -1000; bmm_w[n] = 0; bmb_e[n] = -1000; bmb_w[n] = 0;
            acc_e[n] = -1000; acc_w[n] = 0; next_ok[n] = -1000; cnt_m[n] = 0;
            p_tm[n] = 0; p_tb[n] = 0; p_bm[n] = 0;
        end
        exp_l2 = '0; exp_scl = '0; exp_cnt = '0;
    endtask

    // Called right after each active edge, with the inputs that edge sampled.
    task automatic model_edge();
        e++;
        for (int n = 0; n < NPHI; n++) begin
            bit c, acc, bmn;
            int w;
            case (mode_r)
                2'd0:    c = p_tm[n] | p_tb[n] | p_bm[n];
                2'd1:    c = p_tm[n] | p_tb[n];
                2'd2:    c = p_tm[n] & p_tb[n];
                default: c = 1'b0;
            endcase
            acc = c && !mask_r[n] && (e >= next_ok[n]);
            if (acc) begin
                w = (wid_r == 0) ? 1 : int'(wid_r);
                acc_e[n] = e;
                acc_w[n] = w;
                next_ok[n] = e + w + ((hold_r > 1) ? int'(hold_r) : 1);
            end
            if (clr_r) cnt_m[n] = 0;
            else if (acc && cnt_m[n] < (1 << CB) - 1) cnt_m[n]++;

            bmn = (bm_r != 0) &&
                  ((mid_r[n] && bot_r[n]) ||
                   (mid_r[n] && (e - bmb_e[n] <= bmb_w[n])) ||
                   (bot_r[n] && (e - bmm_e[n] <= bmm_w[n])));
            if (mid_r[n] && mt_r != 0) begin mt_e[n] = e; mt_w[n] = int'(mt_r); end
            if (bot_r[n] && bt_r != 0) begin bt_e[n] = e; bt_w[n] = int'(bt_r); end
            if (mid_r[n] && bm_r != 0) begin bmm_e[n] = e; bmm_w[n] = int'(bm_r); end
            if (bot_r[n] && bm_r != 0) begin bmb_e[n] = e; bmb_w[n] = int'(bm_r); end
            p_tm[n] = top_r[n] && (e - mt_e[n] <= mt_w[n]);
            p_tb[n] = top_r[n] && (e - bt_e[n] <= bt_w[n]);
            p_bm[n] = bmn;

            exp_l2[n]  = (e >= acc_e[n] + 1) && (e <= acc_e[n] + acc_w[n]);
            exp_scl[n] = (e == acc_e[n] + 1);
            exp_cnt[n*CB +: CB] = CB'(cnt_m[n]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_cfg(input int md, input int mt, input int bt, input int bm,
                           input int wd, input int ho);
        mode_r = 2'(md); mt_r = WB'(mt); bt_r = WB'(bt); bm_r = WB'(bm);
        wid_r = WB'(wd); hold_r = WB'(ho);
    endtask

    // Drives one scenario on sector s (pulse edges relative to i=0, -1 = none;
    // burst>0 gives mid+top every cycle for that many cycles) and records what
    // the DUT did plus how many cycles disagreed with the model.
    task automatic pulse_seq(input int s, input int mid_at, input int bot_at,
                             input int top_at, input int burst, input int clr_at,
                             input int ncyc, output int highs, output int first,
                             output int second, output int nrise, output int scls,
                             output int mdiff);
        logic prev;
        highs = 0; first = -1; second = -1; nrise = 0; scls = 0; mdiff = 0;
        clr_r = 1'b1; tick(); clr_r = 1'b0;
        prev = l2_w[s];
        for (int i = 0; i < ncyc; i++) begin
            mid_r[s] = (i == mid_at) || (i < burst);
            top_r[s] = (i == top_at) || (i < burst);
            bot_r[s] = (i == bot_at);
            clr_r    = (i == clr_at);
            tick();
            top_r = '0; mid_r = '0; bot_r = '0; clr_r = 1'b0;
            if (l2_w !== exp_l2 || scl_w !== exp_scl || cnt_w !== exp_cnt) mdiff++;
            if (l2_w[s] === 1'b1) highs++;
            if (scl_w[s] === 1'b1) scls++;
            if (l2_w[s] === 1'b1 && prev !== 1'b1) begin
                nrise++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
            prev = l2_w[s];
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (l2_w !== '0) begin n_fail++; $display("FAIL reset_l2_in_reset: got %b want 0", l2_w); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (l2_w !== '0) begin n_fail++; $display("FAIL reset_l2: got %b want 0", l2_w); end
        n_cmp++; if (scl_w !== '0) begin n_fail++; $display("FAIL reset_scaler: got %b want 0", scl_w); end
        n_cmp++; if (cnt_w !== '0) begin n_fail++; $display("FAIL reset_count: got %h want 0", cnt_w); end
    endtask

    task automatic test_mt_window();
        int h, f, f2, nr, sc, md;
        set_cfg(0, 2, 0, 0, 3, 0);
        pulse_seq(0, 2, -1, 4, 0, -1, 14, h, f, f2, nr, sc, md);
        n_cmp++; if (md !== 0) begin n_fail++; $display("FAIL mt_edge2_model: %0d cycles differ, want 0", md); end
        n_cmp++; if (h !== 3 || f !== 6) begin n_fail++; $display("FAIL mt_edge2_pulse: highs %0d first %0d, want 3 at 6", h, f); end
        n_cmp++; if (sc !== 1) begin n_fail++; $display("FAIL mt_edge2_scaler: got %0d want 1", sc); end
        n_cmp++; if (cnt_w !== 8'h01 || l2_w[1] !== 1'b0) begin n_fail++; $display("FAIL mt_edge2_count: got %h want 01", cnt_w); end
        pulse_seq(0, 2, -1, 5, 0, -1, 14, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 0 || md !== 0) begin n_fail++; $display("FAIL mt_late_top: highs %0d diff %0d, want 0 0", h, md); end
        pulse_seq(0, 2, -1, 1, 0, -1, 14, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 0 || md !== 0) begin n_fail++; $display("FAIL mt_early_top: highs %0d diff %0d, want 0 0", h, md); end
        set_cfg(0, 2, 0, 0, 0, 0);
        pulse_seq(1, 3, -1, 3, 0, -1, 10, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 1 || f !== 5 || md !== 0) begin n_fail++; $display("FAIL width_zero: highs %0d first %0d diff %0d, want 1 5 0", h, f, md); end
    endtask

    task automatic test_bm_window();
        int h, f, f2, nr, sc, md;
        set_cfg(0, 0, 0, 1, 3, 0);
        pulse_seq(0, 3, 2, -1, 0, -1, 12, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 3 || f !== 5 || md !== 0) begin n_fail++; $display("FAIL bm_adjacent: highs %0d first %0d diff %0d, want 3 5 0", h, f, md); end
        pulse_seq(0, 4, 2, -1, 0, -1, 12, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 0 || md !== 0) begin n_fail++; $display("FAIL bm_gap2: highs %0d diff %0d, want 0 0", h, md); end
        set_cfg(1, 0, 0, 1, 3, 0);
        pulse_seq(0, 3, 2, -1, 0, -1, 12, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 0 || md !== 0) begin n_fail++; $display("FAIL bm_topreq: highs %0d diff %0d, want 0 0", h, md); end
    endtask

    task automatic test_mode_all3();
        int h, f, f2, nr, sc, md;
        set_cfg(2, 3, 3, 0, 3, 0);
        pulse_seq(1, 1, 2, 3, 0, -1, 12, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 3 || f !== 5 || md !== 0) begin n_fail++; $display("FAIL all3_hit: highs %0d first %0d diff %0d, want 3 5 0", h, f, md); end
        pulse_seq(1, 1, -1, 3, 0, -1, 12, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 0 || md !== 0) begin n_fail++; $display("FAIL all3_nobot: highs %0d diff %0d, want 0 0", h, md); end
    endtask

    task automatic test_holdoff_mask();
        int h, f, f2, nr, sc, md;
        set_cfg(0, 2, 0, 0, 2, 4);
        pulse_seq(0, -1, -1, -1, 20, -1, 28, h, f, f2, nr, sc, md);
        n_cmp++; if (md !== 0) begin n_fail++; $display("FAIL holdoff_model: %0d cycles differ, want 0", md); end
        n_cmp++; if (nr !== 4 || f !== 2 || f2 - f !== 6) begin n_fail++; $display("FAIL holdoff_rises: n %0d first %0d gap %0d, want 4 2 6", nr, f, f2 - f); end
        n_cmp++; if (cnt_w[3:0] !== 4'd4 || h !== 8) begin n_fail++; $display("FAIL holdoff_count: cnt %0d highs %0d, want 4 8", cnt_w[3:0], h); end
        mask_r = 2'b01;
        pulse_seq(0, -1, -1, -1, 20, -1, 28, h, f, f2, nr, sc, md);
        mask_r = 2'b00;
        n_cmp++; if (h !== 0 || cnt_w !== '0 || md !== 0) begin n_fail++; $display("FAIL mask: highs %0d cnt %h diff %0d, want 0 0 0", h, cnt_w, md); end
    endtask

    task automatic test_saturation_clear();
        int h, f, f2, nr, sc, md;
        set_cfg(0, 2, 0, 0, 1, 0);
        pulse_seq(0, -1, -1, -1, 46, -1, 50, h, f, f2, nr, sc, md);
        n_cmp++; if (cnt_w[3:0] !== 4'hF || nr !== 23 || md !== 0) begin n_fail++; $display("FAIL saturate: cnt %0d accepts %0d diff %0d, want 15 23 0", cnt_w[3:0], nr, md); end
        clr_r = 1'b1; tick(); clr_r = 1'b0;
        n_cmp++; if (cnt_w !== '0) begin n_fail++; $display("FAIL clear: got %h want 0", cnt_w); end
        pulse_seq(0, 0, -1, 0, 0, 1, 6, h, f, f2, nr, sc, md);
        n_cmp++; if (cnt_w !== '0 || h !== 1 || md !== 0) begin n_fail++; $display("FAIL clear_vs_accept: cnt %h highs %0d diff %0d, want 0 1 0", cnt_w, h, md); end
    endtask

    task automatic test_async_reset();
        int h, f, f2, nr, sc, md;
        set_cfg(0, 2, 0, 0, 7, 0);
        mid_r = 2'b01; top_r = 2'b01;
        tick();
        mid_r = '0; top_r = '0;
        tick();
        tick();
        n_cmp++; if (l2_w[0] !== 1'b1) begin n_fail++; $display("FAIL areset_pre_fire: got %b want 1", l2_w[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (l2_w !== '0 || scl_w !== '0 || cnt_w !== '0) begin n_fail++; $display("FAIL areset_drop: l2 %b scl %b cnt %h, want 0", l2_w, scl_w, cnt_w); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        n_cmp++; if (l2_w !== '0) begin n_fail++; $display("FAIL areset_idle: got %b want 0", l2_w); end
        pulse_seq(0, 0, -1, 0, 0, -1, 12, h, f, f2, nr, sc, md);
        n_cmp++; if (h !== 7 || f !== 2 || md !== 0) begin n_fail++; $display("FAIL areset_refire: highs %0d first %0d diff %0d, want 7 2 0", h, f, md); end
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 10; blk++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            mask_r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            for (int i = 0; i < 80; i++) begin
                if (i < 60) begin
                    top_r = 2'($urandom) & 2'($urandom);
                    mid_r = 2'($urandom) & 2'($urandom);
                    bot_r = 2'($urandom) & 2'($urandom);
                end
                clr_r = ($urandom_range(0, 40) == 0);
                tick();
                top_r = '0; mid_r = '0; bot_r = '0; clr_r = 1'b0;
                n_cmp++; if (l2_w !== exp_l2) begin n_fail++; $display("FAIL rand_l2 blk %0d cyc %0d: got %b want %b", blk, i, l2_w, exp_l2); end
                n_cmp++; if (scl_w !== exp_scl) begin n_fail++; $display("FAIL rand_scaler blk %0d cyc %0d: got %b want %b", blk, i, scl_w, exp_scl); end
                n_cmp++; if (cnt_w !== exp_cnt) begin n_fail++; $display("FAIL rand_count blk %0d cyc %0d: got %h want %h", blk, i, cnt_w, exp_cnt); end
            end
        end
        mask_r = '0;
    endtask

    initial begin
        test_reset();
        test_mt_window();
        test_bm_window();
        test_mode_all3();
        test_holdoff_mask();
        test_saturation_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
